// File: rtl/alut_apb_pkg15.sv
// Shared types and STATUS bit positions for the ALUT APB initiator.
package alut_apb_pkg15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        STEP_D_L    = 3'd0,
        STEP_D_U    = 3'd1,
        STEP_S_L    = 3'd2,
        STEP_S_U    = 3'd3,
        STEP_S_PORT = 3'd4,
        STEP_STATUS = 3'd5,
        STEP_D_PORT = 3'd6,
        STEP_CMD    = 3'd7
    } step_t;

    localparam int STATUS_ACTIVE = 0;
    localparam int STATUS_INVAL  = 1;
    localparam int STATUS_REUSED = 2;

    // Checker is busy while either a lookup or an invalidation is in flight.
    function automatic logic status_busy(input logic [31:0] st);
        return st[STATUS_ACTIVE] | st[STATUS_INVAL];
    endfunction

endpackage

// File: rtl/alut_apb_xfer15.sv
// Single APB transfer engine: start launches SETUP, then ACCESS; a new start in ACCESS chains directly.
module alut_apb_xfer15 #(
    parameter int ABUS_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ABUS_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic                  write,
    input  logic [31:0]           prdata,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ABUS_WIDTH-1:0] paddr,
    output logic [31:0]           pwdata,
    output logic                  done,
    output logic [31:0]           rdata
);

    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ABUS_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]           pwdata_q, pwdata_d;

    always_comb begin
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        if (start) begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = write;
            paddr_d   = addr;
            pwdata_d  = write ? wdata : 32'd0;
        end else if (psel_q && !penable_q) begin
            penable_d = 1'b1;
        end else begin
            // Bus idle: paddr keeps its last value, data and control return to zero.
            psel_d    = 1'b0;
            penable_d = 1'b0;
            pwrite_d  = 1'b0;
            pwdata_d  = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= 32'd0;
        end else begin
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign done    = psel_q & penable_q;
    assign rdata   = done ? prdata : 32'd0;

endmodule

// File: rtl/alut_defines15.sv
// ALUT register bank addresses, shared by every block that talks to the bank.
`ifndef ALUT_DEFINES15_SV
`define ALUT_DEFINES15_SV
`define AL_FRM_D_ADDR_L 7'h00
`define AL_FRM_D_ADDR_U 7'h04
`define AL_FRM_S_ADDR_L 7'h08
`define AL_FRM_S_ADDR_U 7'h0C
`define AL_S_PORT       7'h10
`define AL_D_PORT       7'h14
`define AL_COMMAND      7'h18
`define AL_STATUS       7'h1C
`endif

// File: rtl/alut_apb_initiator15.sv
// ALUT APB initiator: turns lookup/command requests into fixed APB write/poll/read sequences.
`include "alut_defines15.sv"

module alut_apb_initiator15 #(
    parameter int POLL_MAX   = 255,
    parameter int ABUS_WIDTH = 7
) (
    input  logic                  pclk15,
    input  logic                  p_reset15,
    input  logic                  req_valid15,
    output logic                  req_ready15,
    input  logic                  req_op15,
    input  logic [47:0]           req_d_addr15,
    input  logic [47:0]           req_s_addr15,
    input  logic [1:0]            req_s_port15,
    input  logic [1:0]            req_cmd15,
    output logic                  rsp_valid15,
    output logic [4:0]            rsp_d_port15,
    output logic                  rsp_reused15,
    output logic                  rsp_timeout15,
    output logic                  psel15,
    output logic                  penable15,
    output logic                  pwrite15,
    output logic [ABUS_WIDTH-1:0] paddr15,
    output logic [31:0]           pwdata15,
    input  logic [31:0]           prdata15
);
    import alut_apb_pkg15::*;

    state_t        state_q, state_d;
    step_t         step_q, step_d;
    logic [15:0]   poll_q, poll_d;
    logic          op_q, op_d;
    logic [47:0]   d_addr_q, d_addr_d, s_addr_q, s_addr_d;
    logic [1:0]    port_q, port_d, cmd_q, cmd_d;
    logic          reused_q, reused_d;
    logic          ready_q, ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [4:0]    rsp_d_port_q, rsp_d_port_d;
    logic          rsp_reused_q, rsp_reused_d;
    logic          rsp_timeout_q, rsp_timeout_d;

    logic                  xfer_start_s, xfer_write_s, xfer_done_s, last_poll_s;
    logic [ABUS_WIDTH-1:0] xfer_addr_s;
    logic [31:0]           xfer_wdata_s, xfer_rdata_s;
    logic                  rdata_unused_s;

    assign last_poll_s    = ({1'b0, poll_q} + 17'd1) >= 17'(POLL_MAX);
    assign rdata_unused_s = ^xfer_rdata_s[31:5];

    // Sequencing FSM: chooses the next transfer at the end of each ACCESS.
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        poll_d        = poll_q;
        op_d          = op_q;
        d_addr_d      = d_addr_q;
        s_addr_d      = s_addr_q;
        port_d        = port_q;
        cmd_d         = cmd_q;
        reused_d      = reused_q;
        rsp_valid_d   = 1'b0;
        rsp_d_port_d  = rsp_d_port_q;
        rsp_reused_d  = rsp_reused_q;
        rsp_timeout_d = rsp_timeout_q;
        xfer_start_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid15 && ready_q) begin
                    op_d         = req_op15;
                    d_addr_d     = req_d_addr15;
                    s_addr_d     = req_s_addr15;
                    port_d       = req_s_port15;
                    cmd_d        = req_cmd15;
                    poll_d       = 16'd0;
                    reused_d     = 1'b0;
                    xfer_start_s = 1'b1;
                    state_d      = ST_SETUP;
                    if (req_op15) begin
                        step_d = STEP_CMD;
                    end else begin
                        step_d = STEP_D_L;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                // Default is to chain straight into the next SETUP; terminal steps override.
                state_d      = ST_SETUP;
                xfer_start_s = 1'b1;
                if (xfer_done_s) begin
                    case (step_q)
                        STEP_D_L:    step_d = STEP_D_U;
                        STEP_D_U:    step_d = STEP_S_L;
                        STEP_S_L:    step_d = STEP_S_U;
                        STEP_S_U:    step_d = STEP_S_PORT;
                        STEP_S_PORT: step_d = STEP_STATUS;
                        STEP_CMD:    step_d = STEP_STATUS;
                        STEP_STATUS: begin
                            poll_d       = poll_q + 16'd1;
                            reused_d     = xfer_rdata_s[STATUS_REUSED];
                            rsp_reused_d = xfer_rdata_s[STATUS_REUSED];
                            if (status_busy(xfer_rdata_s)) begin
                                if (last_poll_s) begin
                                    state_d       = ST_RESP;
                                    xfer_start_s  = 1'b0;
                                    rsp_valid_d   = 1'b1;
                                    rsp_timeout_d = 1'b1;
                                    rsp_d_port_d  = 5'd0;
                                end else begin
                                    step_d = STEP_STATUS;
                                end
                            end else if (!op_q) begin
                                step_d = STEP_D_PORT;
                            end else begin
                                state_d       = ST_RESP;
                                xfer_start_s  = 1'b0;
                                rsp_valid_d   = 1'b1;
                                rsp_timeout_d = 1'b0;
                                rsp_d_port_d  = 5'd0;
                            end
                        end
                        STEP_D_PORT: begin
                            state_d       = ST_RESP;
                            xfer_start_s  = 1'b0;
                            rsp_valid_d   = 1'b1;
                            rsp_timeout_d = 1'b0;
                            rsp_d_port_d  = xfer_rdata_s[4:0];
                            rsp_reused_d  = reused_q;
                        end
                        default: begin
                            state_d      = ST_IDLE;
                            xfer_start_s = 1'b0;
                        end
                    endcase
                end else begin
                    state_d      = ST_IDLE;
                    xfer_start_s = 1'b0;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // Address/data for the transfer about to be launched.
    always_comb begin
        xfer_write_s = 1'b1;
        xfer_wdata_s = 32'd0;
        xfer_addr_s  = ABUS_WIDTH'(`AL_STATUS);
        case (step_d)
            STEP_D_L: begin
                xfer_addr_s  = ABUS_WIDTH'(`AL_FRM_D_ADDR_L);
                xfer_wdata_s = d_addr_d[31:0];
            end
            STEP_D_U: begin
                xfer_addr_s  = ABUS_WIDTH'(`AL_FRM_D_ADDR_U);
                xfer_wdata_s = {16'd0, d_addr_d[47:32]};
            end
            STEP_S_L: begin
                xfer_addr_s  = ABUS_WIDTH'(`AL_FRM_S_ADDR_L);
                xfer_wdata_s = s_addr_d[31:0];
            end
            STEP_S_U: begin
                xfer_addr_s  = ABUS_WIDTH'(`AL_FRM_S_ADDR_U);
                xfer_wdata_s = {16'd0, s_addr_d[47:32]};
            end
            STEP_S_PORT: begin
                xfer_addr_s  = ABUS_WIDTH'(`AL_S_PORT);
                xfer_wdata_s = {30'd0, port_d};
            end
            STEP_CMD: begin
                xfer_addr_s  = ABUS_WIDTH'(`AL_COMMAND);
                xfer_wdata_s = {30'd0, cmd_d};
            end
            STEP_STATUS: begin
                xfer_addr_s  = ABUS_WIDTH'(`AL_STATUS);
                xfer_write_s = 1'b0;
            end
            STEP_D_PORT: begin
                xfer_addr_s  = ABUS_WIDTH'(`AL_D_PORT);
                xfer_write_s = 1'b0;
            end
            default: xfer_write_s = 1'b0;
        endcase
    end

    // State, request latches and response registers.
    always_ff @(posedge pclk15 or posedge p_reset15) begin
        if (p_reset15) begin
            state_q       <= ST_IDLE;
            step_q        <= STEP_D_L;
            poll_q        <= 16'd0;
            op_q          <= 1'b0;
            d_addr_q      <= 48'd0;
            s_addr_q      <= 48'd0;
            port_q        <= 2'd0;
            cmd_q         <= 2'd0;
            reused_q      <= 1'b0;
            ready_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_d_port_q  <= 5'd0;
            rsp_reused_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            poll_q        <= poll_d;
            op_q          <= op_d;
            d_addr_q      <= d_addr_d;
            s_addr_q      <= s_addr_d;
            port_q        <= port_d;
            cmd_q         <= cmd_d;
            reused_q      <= reused_d;
            ready_q       <= ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_d_port_q  <= rsp_d_port_d;
            rsp_reused_q  <= rsp_reused_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    alut_apb_xfer15 #(.ABUS_WIDTH(ABUS_WIDTH)) u_xfer (
        .clk     (pclk15),
        .rst     (p_reset15),
        .start   (xfer_start_s),
        .addr    (xfer_addr_s),
        .wdata   (xfer_wdata_s),
        .write   (xfer_write_s),
        .prdata  (prdata15),
        .psel    (psel15),
        .penable (penable15),
        .pwrite  (pwrite15),
        .paddr   (paddr15),
        .pwdata  (pwdata15),
        .done    (xfer_done_s),
        .rdata   (xfer_rdata_s)
    );

    assign req_ready15   = ready_q;
    assign rsp_valid15   = rsp_valid_q;
    assign rsp_d_port15  = rsp_d_port_q;
    assign rsp_reused15  = rsp_reused_q;
    assign rsp_timeout15 = rsp_timeout_q;

endmodule

// File: tb/tb_alut_apb_initiator15.sv
// Bench for alut_apb_initiator15: table of requests against a scripted ALUT slave, scoreboarded transfers and responses.
module tb_alut_apb_initiator15;

    localparam int POLL_MAX = 4;
    localparam logic [6:0] A_D_L = 7'h00, A_D_U = 7'h04, A_S_L = 7'h08, A_S_U = 7'h0C;
    localparam logic [6:0] A_S_PORT = 7'h10, A_D_PORT = 7'h14, A_CMD = 7'h18, A_STATUS = 7'h1C;

    logic        pclk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_op = 1'b0;
    logic [47:0] req_d = 48'd0, req_s = 48'd0;
    logic [1:0]  req_port = 2'd0, req_cmd = 2'd0;
    logic        rsp_valid, rsp_reused, rsp_timeout;
    logic [4:0]  rsp_d_port;
    logic        psel, penable, pwrite;
    logic [6:0]  paddr;
    logic [31:0] pwdata, prdata;

    always #5 pclk = ~pclk;

    alut_apb_initiator15 #(.POLL_MAX(POLL_MAX), .ABUS_WIDTH(7)) dut (
        .pclk15(pclk), .p_reset15(rst), .req_valid15(req_valid), .req_ready15(req_ready),
        .req_op15(req_op), .req_d_addr15(req_d), .req_s_addr15(req_s), .req_s_port15(req_port),
        .req_cmd15(req_cmd), .rsp_valid15(rsp_valid), .rsp_d_port15(rsp_d_port),
        .rsp_reused15(rsp_reused), .rsp_timeout15(rsp_timeout), .psel15(psel), .penable15(penable),
        .pwrite15(pwrite), .paddr15(paddr), .pwdata15(pwdata), .prdata15(prdata)
    );

    typedef struct {
        logic op; logic [47:0] d; logic [47:0] s; logic [1:0] port; logic [1:0] cmd;
        int busy; logic [1:0] bb; logic reused; logic [4:0] dport;
        logic [4:0] exp_dport; logic exp_to; logic exp_reused; int exp_lat;
    } vec_t;
    typedef struct { logic wr; logic [6:0] addr; logic [31:0] data; } xfer_t;
    typedef struct { logic [4:0] dport; logic to; logic reused; int at_cyc; } rsp_t;

    xfer_t exp_x[$];
    rsp_t  exp_r[$];
    int    n_cmp = 0, n_bad = 0, cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge pclk) cyc <= cyc + 1;

    // Scripted ALUT slave: registers read data during SETUP, STATUS busy for busy_cfg reads.
    int          busy_cfg = 0, st_cnt = 0;
    logic [1:0]  bb_cfg = 2'b01;
    logic        reused_cfg = 1'b0;
    logic [4:0]  dport_cfg = 5'd0;
    logic [31:0] mem [0:127];

    always @(posedge pclk) begin
        if (psel && !penable && !pwrite) begin
            if (paddr == A_STATUS) begin
                if (st_cnt < busy_cfg) prdata <= {29'd0, ~reused_cfg, bb_cfg};
                else                   prdata <= {29'd0, reused_cfg, 2'b00};
                st_cnt <= st_cnt + 1;
            end else if (paddr == A_D_PORT) begin
                prdata <= {27'd0, dport_cfg};
            end else begin
                prdata <= mem[paddr];
            end
        end
        if (psel && penable && pwrite) begin
            mem[paddr] <= pwdata;
            st_cnt     <= 0;
        end
    end

    // Monitor: protocol checks, transfer and response scoreboard.
    logic       prev_psel = 1'b0, prev_pen = 1'b0, prev_pwrite = 1'b0, busy_q = 1'b0;
    logic [6:0] prev_paddr = 7'd0;
    logic [31:0] prev_pwdata = 32'd0;

    always @(negedge pclk) begin
        if (!rst) begin
            if (penable) begin
                chk("pen_after_setup", {62'd0, prev_psel, prev_pen}, 64'd2);
                chk("psel_with_pen", psel, 1'b1);
                chk("paddr_stable", paddr, prev_paddr);
                chk("pwrite_stable", pwrite, prev_pwrite);
                chk("pwdata_stable", pwdata, prev_pwdata);
            end
            if (!psel || !pwrite) chk("pwdata_zero", pwdata, 32'd0);
            if (busy_q) chk("ready_while_busy", req_ready, 1'b0);
            if (psel && penable) begin
                if (exp_x.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_xfer: got addr %0h wr %0b expected none", paddr, pwrite);
                end else begin
                    xfer_t e;
                    e = exp_x.pop_front();
                    chk("xfer_write", pwrite, e.wr);
                    chk("xfer_addr", paddr, e.addr);
                    chk("xfer_wdata", pwdata, e.data);
                end
            end
            if (rsp_valid) begin
                if (exp_r.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid expected none");
                end else begin
                    rsp_t r;
                    r = exp_r.pop_front();
                    chk("rsp_cycle", cyc, r.at_cyc);
                    chk("rsp_d_port", rsp_d_port, r.dport);
                    chk("rsp_timeout", rsp_timeout, r.to);
                    chk("rsp_reused", rsp_reused, r.reused);
                end
            end
            if (req_valid && req_ready) busy_q <= 1'b1;
            else if (rsp_valid)         busy_q <= 1'b0;
        end else begin
            busy_q <= 1'b0;
        end
        prev_psel   <= psel;
        prev_pen    <= penable;
        prev_pwrite <= pwrite;
        prev_paddr  <= paddr;
        prev_pwdata <= pwdata;
    end

    function automatic vec_t mk(input logic op, input logic [47:0] d, input logic [47:0] s,
                                input logic [1:0] port, input logic [1:0] cmd, input int busy,
                                input logic [1:0] bb, input logic reused, input logic [4:0] dport,
                                input logic [4:0] edp, input logic eto, input logic eru, input int lat);
        vec_t v;
        v.op = op; v.d = d; v.s = s; v.port = port; v.cmd = cmd; v.busy = busy; v.bb = bb;
        v.reused = reused; v.dport = dport; v.exp_dport = edp; v.exp_to = eto;
        v.exp_reused = eru; v.exp_lat = lat;
        return v;
    endfunction

    task automatic push_x(input logic wr, input logic [6:0] a, input logic [31:0] d);
        xfer_t e;
        e.wr = wr; e.addr = a; e.data = d;
        exp_x.push_back(e);
    endtask

    task automatic push_expect(input vec_t v, input int c0);
        rsp_t r;
        int   n;
        if (!v.op) begin
            push_x(1'b1, A_D_L, v.d[31:0]);
            push_x(1'b1, A_D_U, {16'd0, v.d[47:32]});
            push_x(1'b1, A_S_L, v.s[31:0]);
            push_x(1'b1, A_S_U, {16'd0, v.s[47:32]});
            push_x(1'b1, A_S_PORT, {30'd0, v.port});
        end else begin
            push_x(1'b1, A_CMD, {30'd0, v.cmd});
        end
        n = (v.busy >= POLL_MAX) ? POLL_MAX : v.busy + 1;
        for (int i = 0; i < n; i++) push_x(1'b0, A_STATUS, 32'd0);
        if (!v.op && v.busy < POLL_MAX) push_x(1'b0, A_D_PORT, 32'd0);
        r.dport = v.exp_dport; r.to = v.exp_to; r.reused = v.exp_reused; r.at_cyc = c0 + v.exp_lat;
        exp_r.push_back(r);
    endtask

    task automatic issue(input vec_t v, output int c0);
        int k;
        @(posedge pclk); #2;
        busy_cfg = v.busy; bb_cfg = v.bb; reused_cfg = v.reused; dport_cfg = v.dport;
        req_valid = 1'b1; req_op = v.op; req_d = v.d; req_s = v.s; req_port = v.port; req_cmd = v.cmd;
        k = 0;
        while (!req_ready && k < 200) begin
            @(posedge pclk); #2;
            k++;
        end
        c0 = cyc;
        if (!req_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL handshake_timeout: got req_ready 0 expected 1 within 200 cycles");
        end else begin
            push_expect(v, c0);
        end
        @(posedge pclk); #2;
        req_valid = 1'b0; req_d = ~v.d; req_s = ~v.s; req_port = ~v.port; req_cmd = ~v.cmd; req_op = ~v.op;
    endtask

    task automatic wait_done(input vec_t v);
        int k;
        k = 0;
        while (exp_r.size() != 0 && k < 300) begin
            @(negedge pclk);
            k++;
        end
        if (exp_r.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_timeout_wait: got no response expected one within 300 cycles");
            exp_r.delete();
        end
        repeat (2) @(negedge pclk);
        chk("rsp_hold_dport", rsp_d_port, v.exp_dport);
        chk("rsp_valid_single", rsp_valid, 1'b0);
        chk("xfers_left", exp_x.size(), 0);
        exp_x.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    vec_t tbl [8];
    int   c0, c1, k;

    initial begin
        tbl[0] = mk(1'b0, 48'h0011_2233_4455, 48'h0A0B_0C0D_0E0F, 2'd2, 2'd0, 0,   2'b01, 1'b0, 5'h07, 5'h07, 1'b0, 1'b0, 15);
        tbl[1] = mk(1'b0, 48'h1234_5678_9ABC, 48'h0FED_CBA9_8765, 2'd1, 2'd0, 3,   2'b01, 1'b1, 5'h13, 5'h13, 1'b0, 1'b1, 21);
        tbl[2] = mk(1'b0, 48'hAAAA_BBBB_CCCC, 48'h0101_0202_0303, 2'd0, 2'd0, 100, 2'b01, 1'b0, 5'h1F, 5'h00, 1'b1, 1'b1, 19);
        tbl[3] = mk(1'b1, 48'd0, 48'd0, 2'd0, 2'b01, 2, 2'b10, 1'b1, 5'h05, 5'h00, 1'b0, 1'b1, 9);
        tbl[4] = mk(1'b1, 48'd0, 48'd0, 2'd0, 2'b00, 0, 2'b10, 1'b0, 5'h05, 5'h00, 1'b0, 1'b0, 5);
        tbl[5] = mk(1'b1, 48'd0, 48'd0, 2'd0, 2'b11, 9, 2'b10, 1'b1, 5'h05, 5'h00, 1'b1, 1'b0, 11);
        tbl[6] = mk(1'b0, 48'hFFFF_0000_FFFF, 48'h8000_0000_0001, 2'd3, 2'd0, 1, 2'b10, 1'b1, 5'h1E, 5'h1E, 1'b0, 1'b1, 17);
        tbl[7] = mk(1'b0, 48'h0F0F_F0F0_1234, 48'h4321_0000_ABCD, 2'd1, 2'd0, 4, 2'b11, 1'b0, 5'h0A, 5'h00, 1'b1, 1'b1, 19);

        // Reset state.
        repeat (3) @(negedge pclk);
        chk("reset_ready", req_ready, 1'b0);
        chk("reset_psel", psel, 1'b0);
        chk("reset_penable", penable, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_fields", {rsp_d_port, rsp_reused, rsp_timeout}, 7'd0);
        chk("reset_pwdata", pwdata, 32'd0);
        rst = 1'b0;
        @(negedge pclk);
        chk("ready_after_reset", req_ready, 1'b1);

        for (int i = 0; i < 8; i++) begin
            issue(tbl[i], c0);
            wait_done(tbl[i]);
            if (i == 0) begin
                chk("frm_d_l", mem[A_D_L], 32'h2233_4455);
                chk("frm_d_u", mem[A_D_U], 32'h0000_0011);
                chk("frm_s_l", mem[A_S_L], 32'h0C0D_0E0F);
                chk("frm_s_u", mem[A_S_U], 32'h0000_0A0B);
                chk("s_port", mem[A_S_PORT], 32'h0000_0002);
            end
        end

        // Back-to-back: second request handshakes the cycle after the first RESP.
        issue(tbl[4], c0);
        issue(tbl[4], c1);
        chk("b2b_handshake", c1, c0 + 6);
        wait_done(tbl[4]);

        // Reset during ACCESS of the third write.
        issue(tbl[0], c0);
        k = 0;
        while (!(psel && penable && paddr == A_S_L) && k < 50) begin
            @(posedge pclk); #1;
            k++;
        end
        chk("reached_write3", {psel, penable, paddr}, {1'b1, 1'b1, A_S_L});
        rst = 1'b1;
        #1;
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        exp_x.delete();
        exp_r.delete();
        repeat (2) @(negedge pclk);
        chk("rst_no_rsp", rsp_valid, 1'b0);
        rst = 1'b0;
        @(negedge pclk);
        chk("ready_after_midreset", req_ready, 1'b1);
        issue(tbl[6], c0);
        wait_done(tbl[6]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
